// File: rtl/cdc_hs_pkg.sv
// cdc_hs_pkg: handshake state encoding and defaults shared by source and destination controllers
package cdc_hs_pkg;
  typedef enum logic [1:0] {IDLE, REQ_HI, REQ_LO, ERR} hs_state_t;
  localparam int HS_SYNC_STAGES_DEF = 2;
endpackage

// File: rtl/bit_sync.sv
// bit_sync: multi-flop synchronizer for a single asynchronous level
module bit_sync #(
  parameter int NUM_OF_FLOPS = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);
  logic [NUM_OF_FLOPS-1:0] r_sync;
  always_ff @(posedge clk) r_sync <= !rstn ? '0 : {r_sync[NUM_OF_FLOPS-2:0], d};
  assign q = r_sync[NUM_OF_FLOPS-1];
endmodule

// File: rtl/cdc_hs_src_ctrl.sv
// cdc_hs_src_ctrl: source side of a four-phase req/ack handshake with a timeout watchdog
module cdc_hs_src_ctrl
  import cdc_hs_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int SYNC_STAGES    = HS_SYNC_STAGES_DEF,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  src_clk,
  input  logic                  rstn,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  xfer_req,
  output logic [DATA_WIDTH-1:0] xfer_data,
  input  logic                  xfer_ack_async,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout,
  input  logic                  err_clr
);
  localparam int CNT_W = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  hs_state_t r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [DATA_WIDTH-1:0] r_data;
  logic r_req, r_busy, r_done, r_timeout;
  logic w_ack_s, w_accept, w_expire, w_waiting;
  bit_sync #(.NUM_OF_FLOPS(SYNC_STAGES)) u_ack_sync (
    .clk (src_clk),
    .rstn(rstn),
    .d   (xfer_ack_async),
    .q   (w_ack_s)
  );
  assign s_ready   = (r_state == IDLE) && !w_ack_s;
  assign w_accept  = s_valid && s_ready;
  assign w_waiting = (r_state == REQ_HI) || (r_state == REQ_LO);
  assign w_expire  = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  // a wait condition met on the expiry cycle takes priority over the watchdog
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_accept ? REQ_HI : IDLE;
      REQ_HI:  w_next = w_ack_s ? REQ_LO : (w_expire ? ERR : REQ_HI);
      REQ_LO:  w_next = !w_ack_s ? IDLE : (w_expire ? ERR : REQ_LO);
      ERR:     w_next = (err_clr && !w_ack_s) ? IDLE : ERR;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge src_clk) begin
    if (!rstn) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_data    <= '0;
      r_req     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_cnt     <= (w_next != r_state) ? '0 : (w_waiting ? r_cnt + 1'b1 : r_cnt);
      r_data    <= w_accept ? s_data : r_data;
      r_req     <= w_next == REQ_HI;
      r_busy    <= w_next != IDLE;
      r_done    <= (r_state == REQ_LO) && (w_next == IDLE);
      r_timeout <= w_next == ERR;
    end
  end
  assign xfer_req  = r_req;
  assign xfer_data = r_data;
  assign busy      = r_busy;
  assign done      = r_done;
  assign timeout   = r_timeout;
endmodule

// File: tb/tb_cdc_hs_src_ctrl.sv
// tb_cdc_hs_src_ctrl: directed handshake scenarios plus randomized traffic against a cycle-level protocol model
module tb_cdc_hs_src_ctrl;
  localparam int DW = 32, SS = 2, TO = 16;
  logic clk = 0, rstn = 0, s_valid = 0, ack = 0, err_clr = 0;
  logic s_ready, xfer_req, busy, done, timeout;
  logic [DW-1:0] s_data = '0, xfer_data;
  int n_chk = 0, n_err = 0;
  always #5 clk = ~clk;
  cdc_hs_src_ctrl #(.DATA_WIDTH(DW), .SYNC_STAGES(SS), .TIMEOUT_CYCLES(TO)) dut (
    .src_clk       (clk),
    .rstn          (rstn),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_data        (s_data),
    .xfer_req      (xfer_req),
    .xfer_data     (xfer_data),
    .xfer_ack_async(ack),
    .busy          (busy),
    .done          (done),
    .timeout       (timeout),
    .err_clr       (err_clr)
  );
  // model: phase 0 idle, 1 waiting ack high, 2 waiting ack low, 3 error; m_wait = cycles spent in current wait
  int m_phase = 0, m_wait = 0;
  logic m_done = 0, m_acc = 0;
  logic [DW-1:0] m_data = '0;
  logic m_q[$];
  bit dst_en = 1;
  int dly = 3, dcnt = 0, n_done = 0, n_acc = 0;
  logic [DW-1:0] done_q[$];
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    logic a;
    bit expire;
    if (dst_en) begin
      dcnt = (ack != (m_phase == 1)) ? dcnt + 1 : 0;
      if (dcnt >= dly) begin
        ack = (m_phase == 1);
        dcnt = 0;
      end
    end
    a = m_q[SS-1];
    expire = (TO != 0) && (m_wait == TO);
    m_done = 0;
    m_acc = 0;
    if (!rstn) begin
      m_phase = 0;
      m_wait = 0;
      m_data = '0;
      m_q = {};
      repeat (SS) m_q.push_back(1'b0);
    end else begin
      case (m_phase)
        0: if (s_valid && !a) begin m_phase = 1; m_wait = 1; m_data = s_data; m_acc = 1; end
        1: if (a) begin m_phase = 2; m_wait = 1; end else if (expire) m_phase = 3; else m_wait++;
        2: if (!a) begin m_phase = 0; m_done = 1; end else if (expire) m_phase = 3; else m_wait++;
        default: if (err_clr && !a) m_phase = 0;
      endcase
      m_q.push_front(ack);
      void'(m_q.pop_back());
    end
    @(negedge clk);
    n_done += int'(done);
    n_acc += int'(m_acc);
    if (done) done_q.push_back(xfer_data);
    chk("req", int'(xfer_req), int'(m_phase == 1));
    chk("busy", int'(busy), int'(m_phase != 0));
    chk("done", int'(done), int'(m_done));
    chk("timeout", int'(timeout), int'(m_phase == 3));
    chk("data", int'(xfer_data), int'(m_data));
    chk("ready", int'(s_ready), int'(m_phase == 0 && !m_q[SS-1]));
  endtask
  task automatic send(input logic [DW-1:0] w);
    int a0;
    a0 = n_acc;
    s_valid = 1;
    s_data = w;
    for (int i = 0; i < 20 && n_acc == a0; i++) tick();
    s_valid = 0;
    chk("accept", int'(busy), 1);
  endtask
  initial begin
    int a0, d0, n;
    repeat (SS) m_q.push_back(1'b0);
    rstn = 0; tick(); tick(); rstn = 1; tick();
    chk("rst_busy", int'(busy), 0);
    // single transfer, s_data scrambled after accept
    dst_en = 1; dly = 3; d0 = n_done;
    send(32'hDEADBEEF);
    for (int i = 0; i < 60 && busy; i++) begin s_data = $urandom; tick(); end
    chk("single_done", n_done - d0, 1);
    chk("single_data", int'(xfer_data), int'(32'hDEADBEEF));
    chk("single_ready", int'(s_ready), 1);
    // back-to-back with s_valid held
    d0 = n_done; a0 = n_acc; done_q = {}; s_valid = 1;
    for (int i = 0; i < 200 && n_acc - a0 < 3; i++) begin s_data = DW'(n_acc - a0 + 1); tick(); end
    s_valid = 0;
    for (int i = 0; i < 60 && busy; i++) tick();
    chk("b2b_done", n_done - d0, 3);
    for (int k = 0; k < 3; k++) chk("b2b_word", int'(k < done_q.size() ? done_q[k] : '1), k + 1);
    // timeout with ack never rising
    dst_en = 0; ack = 0; d0 = n_done;
    send(32'hA5A50001);
    n = 0;
    for (int i = 0; i < 100 && !timeout; i++) begin tick(); n++; end
    chk("to_latency", n, TO);
    chk("to_req", int'(xfer_req), 0);
    chk("to_done", n_done - d0, 0);
    // err_clr gated by synchronized ack
    ack = 1; repeat (4) tick();
    err_clr = 1; tick(); err_clr = 0; tick();
    chk("errclr_hold", int'(timeout), 1);
    ack = 0; repeat (4) tick();
    err_clr = 1; tick(); err_clr = 0;
    chk("errclr_to", int'(timeout), 0);
    chk("errclr_busy", int'(busy), 0);
    // stale ack while idle blocks accept
    ack = 1; repeat (3) tick();
    s_valid = 1; s_data = 32'h00005A5A;
    repeat (5) begin tick(); chk("stale_ready", int'(s_ready), 0); end
    chk("stale_busy", int'(busy), 0);
    ack = 0; a0 = n_acc;
    for (int i = 0; i < 10 && n_acc == a0; i++) tick();
    s_valid = 0;
    chk("stale_accept", int'(busy), 1);
    dst_en = 1; dcnt = 0; dly = 2;
    for (int i = 0; i < 60 && busy; i++) tick();
    chk("stale_idle", int'(busy), 0);
    // reset during REQ_LO
    dly = 3;
    send(32'h00C0FFEE);
    for (int i = 0; i < 60 && !(busy && !xfer_req); i++) tick();
    chk("rst_reqlo", int'(busy && !xfer_req && !timeout), 1);
    d0 = n_done;
    rstn = 0; tick(); rstn = 1;
    chk("rst_req", int'(xfer_req), 0);
    chk("rst_data", int'(xfer_data), 0);
    chk("rst_busy2", int'(busy), 0);
    chk("rst_to", int'(timeout), 0);
    repeat (10) tick();
    chk("rst_nodone", n_done - d0, 0);
    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      s_valid = 1'($urandom_range(0, 1));
      s_data = $urandom;
      err_clr = ($urandom_range(0, 9) == 0);
      rstn = ($urandom_range(0, 599) != 0);
      if ($urandom_range(0, 249) == 0) begin dst_en = !dst_en; dcnt = 0; end
      if (dcnt == 0) dly = $urandom_range(1, 6);
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/cdc_hs_src_ctrl.md
# cdc_hs_src_ctrl

Source-side controller for a four-phase req/ack clock-domain-crossing handshake. It accepts a data word from a ready/valid producer in the `src_clk` domain and holds the word stable on `xfer_data`. It drives `xfer_req` through the full four-phase sequence and synchronizes the returning `xfer_ack_async` through an internal `bit_sync`. A timeout watchdog aborts a stalled transfer into a sticky error state.

## Interface
- `DATA_WIDTH`, 32: width of transferred word.
- `SYNC_STAGES`, 2: flop count of the ack synchronizer; legal range ≥2.
- `TIMEOUT_CYCLES`, 1024: maximum `src_clk` cycles spent in either wait state; 0 disables the watchdog.
- `CNT_W`, `$clog2(TIMEOUT_CYCLES+1)`: local width of the watchdog counter; not overridable.

Ports:
- `src_clk`  in  1  clock; all logic on its rising edge. One clock only.
- `rstn`  in  1  reset, synchronous, active-low.
- `s_valid`  in  1  producer word valid.
- `s_ready`  out  1  controller can accept a word.
- `s_data`  in  `DATA_WIDTH`  producer word.
- `xfer_req`  out  1  request to destination domain; registered, glitch-free.
- `xfer_data`  out  `DATA_WIDTH`  captured word; stable while `xfer_req`=1 and until the next accept.
- `xfer_ack_async`  in  1  destination acknowledge, asynchronous to `src_clk`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when a transfer completes.
- `timeout`  out  1  sticky error flag.
- `err_clr`  in  1  clears `timeout` and leaves the error state.

## Operation
- `ack_s` is `xfer_ack_async` passed through `bit_sync` with `NUM_OF_FLOPS=SYNC_STAGES`.
- `s_ready` = (state==IDLE) && !`ack_s`. This is combinational and blocks any start while a stale ack is high.
- Accept occurs when `s_valid` && `s_ready`. On that edge:
  - `xfer_data` <= `s_data`.
  - `xfer_req` <= 1.
  - state -> REQ_HI.
- REQ_HI: wait for `ack_s`=1. On that edge, `xfer_req` <= 0 and state -> REQ_LO.
- REQ_LO: wait for `ack_s`=0. On that edge, state -> IDLE and `done` <= 1 for exactly one cycle.
- ERR:
  - Entered from REQ_HI or REQ_LO when the watchdog expires.
  - On entry, `xfer_req` <= 0 and `timeout` <= 1.
  - Exits to IDLE on `err_clr`=1 && `ack_s`=0. On that edge `timeout` <= 0.
  - `err_clr` while `ack_s`=1 is ignored; state stays ERR.
  - `err_clr` outside ERR has no effect.
- Watchdog counter:
  - Cleared on every state entry.
  - Increments each cycle in REQ_HI or REQ_LO.
  - Expiry when count == `TIMEOUT_CYCLES`-1 and the wait condition is still unmet. Expiry takes the next edge into ERR.
  - If the wait condition and expiry coincide, the wait condition wins and the normal transition is taken.
- `xfer_data` changes only on accept.
- `s_data` changes while not accepted are ignored.

## Timing
- All outputs are registered except `s_ready`, which is combinational from state and `ack_s`.
- Reset values: state IDLE, `xfer_req` 0, `xfer_data` 0, `busy` 0, `done` 0, `timeout` 0, counter 0, synchronizer flops 0.
- Reset applied mid-transfer forces these values on the next edge. No `done` is produced for the aborted word.
- Ack synchronization latency: `SYNC_STAGES` cycles, plus one edge for the state change.
- Back-to-back transfers: `s_ready` reasserts in the cycle after `done` is issued, provided `ack_s`=0. Maximum throughput is one word per 2·(`SYNC_STAGES`+1)+1 cycles plus destination latency.
- `busy` goes high on the edge after accept and low on the edge that asserts `done`.

## Structure
- Package `cdc_hs_pkg`:
  - `typedef enum logic [1:0] {IDLE, REQ_HI, REQ_LO, ERR} hs_state_t`.
  - Shared constant `HS_SYNC_STAGES_DEF=2`.
  - The package is reused by the future destination-side controller.
- Sub-module: one `bit_sync` instance for `xfer_ack_async`.
- Everything else is a single FSM process plus the counter, in this module.

## Test plan
- **Single transfer.** Setup: `DATA_WIDTH`=32, `SYNC_STAGES`=2. Send `s_data`=0xDEADBEEF. The destination model raises ack 3 cycles after req and drops it 3 cycles after req falls. Required: `xfer_data`=0xDEADBEEF stable throughout, exactly one `done` pulse, `s_ready` high again afterwards.
- **Back-to-back.** Hold `s_valid` high with words 0x1, 0x2, 0x3. Required: three accepts in order, three `done` pulses, and `xfer_data` never changes while `xfer_req`=1.
- **Timeout.** Setup: `TIMEOUT_CYCLES`=16, ack never rises. Required: ERR entered exactly 16 cycles after REQ_HI entry; `xfer_req`=0, `timeout`=1, `done` never pulses.
- **Error clear gated by ack.** While in ERR with ack held high, pulse `err_clr`. Required: state remains ERR. Then drop ack and pulse `err_clr`. Required: IDLE reached and `timeout`=0.
- **Stale ack at idle.** Hold ack high while in IDLE with `s_valid`=1. Required: `s_ready`=0 and no accept until `ack_s` falls.
- **Reset mid-transfer.** Assert `rstn`=0 for one cycle while in REQ_LO. Required: all outputs at reset values on the next edge, and no `done` pulse.
